// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional parity, one or two
// stop bits. Every output is a flop that holds the bit currently on the line.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_MODE,
  input  logic                  STOP_2,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  TX_DONE
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  par_en_q, par_en_d;
  logic [1:0]            par_mode_q, par_mode_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] word,
                                      input logic [1:0]            mode);
    case (mode)
      2'b00:   return ^word;
      2'b01:   return ~^word;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Next-state logic computes the bit that will be on the line after the edge,
  // so the output flops change together with the state register.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    par_en_d   = par_en_q;
    par_mode_d = par_mode_q;
    stop2_d    = stop2_q;
    tx_d       = 1'b1;
    busy_d     = 1'b1;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (DATA_VALID) begin
          state_d    = S_START;
          data_d     = P_DATA;
          par_en_d   = PAR_EN;
          par_mode_d = PAR_MODE;
          stop2_d    = STOP_2;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_START: begin
        state_d = S_DATA;
        cnt_d   = '0;
        tx_d    = data_q[0];
      end
      S_DATA: begin
        if (cnt_q == LAST_BIT) begin
          if (par_en_q) begin
            state_d = S_PARITY;
            tx_d    = parity_bit(data_q, par_mode_q);
          end else begin
            state_d = S_STOP1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          tx_d  = data_q[cnt_d];
        end
      end
      S_PARITY: state_d = S_STOP1;
      S_STOP1: begin
        if (stop2_q) begin
          state_d = S_STOP2;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_STOP2: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      cnt_q      <= '0;
      par_en_q   <= 1'b0;
      par_mode_q <= 2'b00;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      par_en_q   <= par_en_d;
      par_mode_q <= par_mode_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign TX_OUT  = tx_q;
  assign BUSY    = busy_q;
  assign TX_DONE = done_q;

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmit framer with built-in parity generation. It replaces the standalone parity calculator plus serializer pair in the UART TX path. It accepts a parallel word on a valid strobe and shifts out a complete frame, one bit per CLK cycle, LSB first: start, data, optional parity, then one or two stop bits. It sits between the system control FSM (word source) and the TX pad; CLK is the UART TX (baud-rate) clock.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal range 5..9

- CLK  in  1  UART TX clock, one serial bit per rising edge
- RST  in  1  asynchronous, active-low reset
- P_DATA  in  DATA_WIDTH  parallel word to transmit
- DATA_VALID  in  1  request to send P_DATA; sampled only when BUSY=0
- PAR_EN  in  1  1 = parity bit inserted after data bits
- PAR_MODE  in  2  00 even, 01 odd, 10 mark (always 1), 11 space (always 0)
- STOP_2  in  1  0 = one stop bit, 1 = two stop bits
- TX_OUT  out  1  serial line, idles high, registered
- BUSY  out  1  frame in progress, registered
- TX_DONE  out  1  one-cycle pulse when a frame completes, registered

## Operation
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: TX_OUT=1, BUSY=0.
  - On DATA_VALID=1, latch P_DATA, PAR_EN, PAR_MODE and STOP_2 into internal registers and go to START.
- START: TX_OUT=0, BUSY=1 -> DATA.
- DATA:
  - TX_OUT = latched bit index i, with i from 0 to DATA_WIDTH-1, LSB first.
  - A bit counter of width clog2(DATA_WIDTH) counts the bits.
  - After bit DATA_WIDTH-1, go to PARITY if the latched PAR_EN=1, else STOP1.
- PARITY: TX_OUT driven per the latched mode, then -> STOP1.
  - Even: XOR-reduce of the latched word (total ones incl. parity even).
  - Odd: inverted XOR-reduce.
  - Mark: 1. Space: 0.
- STOP1: TX_OUT=1. Next state is STOP2 if the latched STOP_2=1, else IDLE.
- STOP2: TX_OUT=1 -> IDLE.
- TX_DONE=1 for exactly the first cycle after the frame returns to IDLE.
- Input isolation:
  - Parity is computed only from the latched word.
  - Changes on P_DATA or the config inputs while BUSY=1 have no effect on the current frame.
- DATA_VALID while BUSY=1 is ignored. It is neither queued nor counted.
- PAR_MODE is ignored when PAR_EN=0.
- Frame length in cycles: 1 + DATA_WIDTH + PAR_EN + (1 + STOP_2).

## Timing
- Reset (RST=0, async): state IDLE, TX_OUT=1, BUSY=0, TX_DONE=0, and data and counter registers cleared.
  - Reset asserted mid-frame aborts the frame immediately with the line high. No TX_DONE is produced.
- Let DATA_VALID=1 be sampled in IDLE at edge k.
  - From edge k: TX_OUT=0 (start bit) and BUSY=1.
  - Data bit i appears from edge k+1+i.
- Let the last stop bit occupy the cycle after edge m.
  - At edge m+1: TX_OUT=1, BUSY=0, TX_DONE=1.
  - At edge m+2: TX_DONE=0.
- Minimum inter-frame gap is one IDLE cycle.
  - DATA_VALID held high continuously produces back-to-back frames with exactly one idle high bit between them.
  - Each frame carries the P_DATA present at its own acceptance edge.
- All outputs come straight from flops, so there are no combinational paths from inputs to outputs.

## Test plan
- Even parity, 1 stop:
  - Stimulus: DATA_WIDTH=8, P_DATA=0xA5, PAR_EN=1, PAR_MODE=00, STOP_2=0, one-cycle DATA_VALID.
  - Response: TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles. BUSY is high for those 11 cycles, then TX_DONE pulses once.
- Odd parity, 2 stops:
  - Stimulus: same word 0xA5, PAR_MODE=01, STOP_2=1.
  - Response: parity bit=1 and two stop bits, 12 cycles total.
  - Repeat with 0x07 odd: parity=0.
- Mark, space and none:
  - Stimulus: P_DATA=0x00 with PAR_MODE=10, then with PAR_MODE=11, then with PAR_EN=0.
  - Response: parity bit=1, then parity bit=0, then no parity slot and a 10-cycle frame.
- Input isolation:
  - Stimulus: change P_DATA to 0xFF, PAR_MODE and STOP_2 mid-frame, and pulse DATA_VALID while BUSY=1.
  - Response: the current frame is unchanged and no second frame starts.
- Reset mid-frame and back-to-back:
  - Stimulus: drop RST during the data bits.
    - Response: TX_OUT=1 and BUSY=0 immediately, no TX_DONE.
  - Stimulus: hold DATA_VALID high with 0x3C then 0xC3.
    - Response: two frames separated by exactly one idle high cycle.
- DATA_WIDTH=5 and DATA_WIDTH=9:
  - Stimulus: all-ones word with even parity.
  - Response: 5 ones gives parity=1; 9 ones gives parity=1. Frame lengths are 8 and 12 cycles.
